// File: rtl/mux_scan_pkg.sv
// -----------------------------------------------------------------------------
// mux_scan_pkg
//   Shared definitions for the DSO capture-path mux sequencer.
//   - scan_state_e : controller state encoding (IDLE / SCAN)
//   - NUM_CH       : number of mux inputs (d0..d3)
//   - next_ch()    : round-robin channel pick over an enable mask
// -----------------------------------------------------------------------------
package mux_scan_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

  localparam int NUM_CH = 4;

  // Returns the first set mask bit strictly above 'cur', wrapping 3->0.
  // If 'cur' is the only set bit it is returned again (the fourth probe
  // lands back on cur). Calling with cur=3 yields the lowest set bit.
  // With an all-zero mask the result is 'cur'; callers never rely on that.
  function automatic logic [1:0] next_ch(input logic [3:0] mask,
                                         input logic [1:0] cur);
    logic [1:0] cand;
    logic [1:0] res;
    logic       found;
    res   = cur;
    found = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = cur + 2'(i);
      if (!found && mask[cand]) begin
        res   = cand;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux_scan_lane.sv
// -----------------------------------------------------------------------------
// mux_scan_lane
//   Per-channel bit packer. Shifts the sampled mux bit in LSB-first so the
//   first sampled bit ends up in the MSB of the finished word.
//
// Ports
//   clk       in   1       system clock
//   rst       in   1       synchronous reset, active-high
//   shift_en  in   1       shift bit_in into this lane this cycle
//   clr       in   1       discard the partial word (contents and count)
//   bit_in    in   1       sampled mux output
//   word      out  WORD_W  shift register contents including bit_in; only
//                          meaningful while word_done is high
//   word_done out  1       this shift completes a WORD_W-bit word
// -----------------------------------------------------------------------------
module mux_scan_lane #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic              clr,
  input  logic              bit_in,
  output logic [WORD_W-1:0] word,
  output logic              word_done
);

  localparam int CNT_W = $clog2(WORD_W);

  // Only WORD_W-1 bits are stored: the last bit of a word is taken straight
  // from bit_in when the word is handed out, and the count wraps to zero
  // on that same edge.
  logic [WORD_W-2:0] sr_q;
  logic [CNT_W-1:0]  cnt_q;

  assign word      = {sr_q, bit_in};
  assign word_done = shift_en && (cnt_q == CNT_W'(WORD_W - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (shift_en) begin
      sr_q  <= word[WORD_W-2:0];
      cnt_q <= word_done ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// mux_scan_ctrl
//   Sequencer/collector around the 4:1 select mux in the DSO capture path.
//   Walks s1/s0 round-robin over the enabled channels, dwelling DWELL cycles
//   on each; samples q_in at dwell cycle SETTLE and packs each channel's bits
//   into WORD_W-bit words, which are offered on a valid/ready output.
//
// Parameters
//   WORD_W  bits per packed word (2..32)
//   DWELL   cycles each channel stays selected (>=2)
//   SETTLE  dwell cycle at which q_in is sampled (1..DWELL-1)
//
// Ports
//   clk, rst    clock; synchronous active-high reset
//   en          scan enable
//   ch_mask     channel enable mask, bit n = mux input dn
//   s0, s1      registered mux selects
//   q_in        mux output (combinational from s1/s0)
//   dout        packed word, first-sampled bit in MSB
//   dout_ch     channel index of dout
//   dout_valid  dout/dout_ch hold a word
//   dout_ready  consumer accepts the word
//   overflow    sticky: a completed word was dropped
//   clr_ovf     clears overflow (a same-cycle drop wins)
//   state_dbg   current controller state
//
// Handshake: a word transfers on every cycle where dout_valid && dout_ready.
// dout/dout_ch are held stable while dout_valid && !dout_ready; dout_valid
// drops after a transfer unless a new word loads on the same edge. A word
// that completes while the register is occupied and not being drained is
// dropped and flags overflow.
// -----------------------------------------------------------------------------
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int DWELL  = 4,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [3:0]        ch_mask,
  output logic              s0,
  output logic              s1,
  input  logic              q_in,
  output logic [WORD_W-1:0] dout,
  output logic [1:0]        dout_ch,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              overflow,
  input  logic              clr_ovf,
  output scan_state_e       state_dbg
);

  localparam int DC_W = $clog2(DWELL);

  // ---------------------------------------------------------------------------
  // Controller state
  // ---------------------------------------------------------------------------
  scan_state_e       state_q, state_d;
  logic [1:0]        sel_q, sel_d;     // drives s1/s0 directly
  logic [DC_W-1:0]   dc_q, dc_d;       // dwell counter

  logic [NUM_CH-1:0] lane_shift;
  logic [NUM_CH-1:0] lane_clr;
  logic [NUM_CH-1:0] lane_done;
  logic [WORD_W-1:0] lane_word [NUM_CH];

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  logic [WORD_W-1:0] dout_q;
  logic [1:0]        dout_ch_q;
  logic              dout_valid_q;
  logic              overflow_q;

  logic              word_done;
  logic              out_free;

  // ---------------------------------------------------------------------------
  // Lanes
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    mux_scan_lane #(
      .WORD_W (WORD_W)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .shift_en  (lane_shift[g]),
      .clr       (lane_clr[g]),
      .bit_in    (q_in),
      .word      (lane_word[g]),
      .word_done (lane_done[g])
    );
  end

  // ---------------------------------------------------------------------------
  // FSM: next state, select, dwell counter, lane controls
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    dc_d       = dc_q;
    lane_shift = '0;
    lane_clr   = '0;

    unique case (state_q)
      ST_IDLE: begin
        sel_d    = 2'd0;
        dc_d     = '0;
        lane_clr = '1;
        if (en && (ch_mask != 4'b0000)) begin
          state_d = ST_SCAN;
          // Probing above channel 3 wraps to 0, so this is the lowest set bit.
          sel_d   = next_ch(ch_mask, 2'd3);
        end
      end

      ST_SCAN: begin
        // Only the selected lane ever shifts, so at most one word completes
        // per cycle.
        if (dc_q == DC_W'(SETTLE)) begin
          lane_shift[sel_q] = 1'b1;
        end

        if (dc_q == DC_W'(DWELL - 1)) begin
          // Dwell boundary: select changes on this edge together with dc->0,
          // giving the mux SETTLE cycles before the next sample.
          dc_d = '0;
          if (!en || (ch_mask == 4'b0000)) begin
            state_d  = ST_IDLE;
            sel_d    = 2'd0;
            lane_clr = '1;
          end else begin
            sel_d    = next_ch(ch_mask, sel_q);
            lane_clr = ~ch_mask;
          end
        end else begin
          dc_d = dc_q + DC_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= 2'd0;
      dc_q    <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      dc_q    <= dc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register and overflow
  // ---------------------------------------------------------------------------
  assign word_done = |lane_done;
  // The register can take a new word if it is empty or being drained now.
  assign out_free  = !dout_valid_q || dout_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q       <= '0;
      dout_ch_q    <= 2'd0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      if (word_done && out_free) begin
        dout_q       <= lane_word[sel_q];
        dout_ch_q    <= sel_q;
        dout_valid_q <= 1'b1;
      end else if (dout_valid_q && dout_ready) begin
        dout_valid_q <= 1'b0;
      end

      // A drop in the same cycle as clr_ovf keeps the flag set.
      if (word_done && !out_free) begin
        overflow_q <= 1'b1;
      end else if (clr_ovf) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign s0         = sel_q[0];
  assign s1         = sel_q[1];
  assign dout       = dout_q;
  assign dout_ch    = dout_ch_q;
  assign dout_valid = dout_valid_q;
  assign overflow   = overflow_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_ctrl
//   Directed scenarios followed by a randomized run. A behavioural model
//   tracks which channel should be selected, collects sampled bits per
//   channel in queues, and forms words arithmetically once a queue holds
//   WW bits. All DUT outputs are compared against the model after every
//   clock, plus explicit constant checks for the directed scenarios.
// -----------------------------------------------------------------------------
module tb_mux_scan_ctrl;
  import mux_scan_pkg::*;

  localparam int WW = 8;
  localparam int DW = 4;
  localparam int ST = 1;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic          clk;
  logic          rst;
  logic          en;
  logic [3:0]    ch_mask;
  logic          s0, s1;
  logic          q_in;
  logic [WW-1:0] dout;
  logic [1:0]    dout_ch;
  logic          dout_valid;
  logic          dout_ready;
  logic          overflow;
  logic          clr_ovf;
  scan_state_e   state_dbg;

  // Per-channel source bits seen at the mux inputs d0..d3.
  logic [3:0]    src_bits;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The mux itself: combinational from the selects.
  assign q_in = src_bits[{s1, s0}];

  mux_scan_ctrl #(
    .WORD_W (WW),
    .DWELL  (DW),
    .SETTLE (ST)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .ch_mask    (ch_mask),
    .s0         (s0),
    .s1         (s1),
    .q_in       (q_in),
    .dout       (dout),
    .dout_ch    (dout_ch),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf),
    .state_dbg  (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard / reference model
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;

  int            m_on;          // 1 while scanning
  int            m_sel;         // channel expected on s1/s0
  int            m_cyc;         // position inside the current dwell
  int            lane_q [4][$]; // bits collected so far, oldest first
  logic [WW-1:0] exp_q [$];     // words the model has offered to dout
  int            m_valid;
  logic [WW-1:0] m_dout;
  int            m_dch;
  int            m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_on    = 0;
    m_sel   = 0;
    m_cyc   = 0;
    m_valid = 0;
    m_dout  = '0;
    m_dch   = 0;
    m_ovf   = 0;
    for (int c = 0; c < 4; c++) lane_q[c].delete();
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    int            done;
    int            acc;
    int            wch;
    int            nxt;
    int            c;
    int            found;
    int            free;
    logic [WW-1:0] w;
    if (rst) begin
      model_reset();
      return;
    end
    done = 0;
    w    = '0;
    wch  = 0;
    free = (m_valid == 0) || dout_ready;
    if (m_on == 0) begin
      if (en && ch_mask != 4'b0000) begin
        m_on  = 1;
        m_cyc = 0;
        found = 0;
        for (int k = 0; k < 4; k++)
          if (found == 0 && ch_mask[k]) begin
            m_sel = k;
            found = 1;
          end
      end
    end else begin
      if (m_cyc == ST) begin
        lane_q[m_sel].push_back(int'(src_bits[m_sel]));
        if (lane_q[m_sel].size() == WW) begin
          acc = 0;
          for (int i = 0; i < WW; i++) acc = acc * 2 + lane_q[m_sel][i];
          w    = acc[WW-1:0];
          wch  = m_sel;
          done = 1;
          lane_q[m_sel].delete();
        end
      end
      if (m_cyc == DW - 1) begin
        m_cyc = 0;
        if (!en || ch_mask == 4'b0000) begin
          m_on  = 0;
          m_sel = 0;
          for (int k = 0; k < 4; k++) lane_q[k].delete();
        end else begin
          for (int k = 0; k < 4; k++) if (!ch_mask[k]) lane_q[k].delete();
          found = 0;
          nxt   = m_sel;
          for (int k = 1; k <= 4; k++) begin
            c = (m_sel + k) % 4;
            if (found == 0 && ch_mask[c]) begin
              nxt   = c;
              found = 1;
            end
          end
          m_sel = nxt;
        end
      end else begin
        m_cyc++;
      end
    end
    if (done != 0 && free != 0) begin
      m_valid = 1;
      m_dout  = w;
      m_dch   = wch;
      exp_q.push_back(w);
    end else if (m_valid != 0 && dout_ready) begin
      m_valid = 0;
    end
    if (done != 0 && free == 0) m_ovf = 1;
    else if (clr_ovf)           m_ovf = 0;
  endtask

  task automatic compare_all();
    chk("sel",        {30'b0, s1, s0},                  m_sel);
    chk("state",      {31'b0, (state_dbg == ST_SCAN)},  m_on);
    chk("dout_valid", {31'b0, dout_valid},              m_valid);
    chk("dout",       {{(32-WW){1'b0}}, dout},          {{(32-WW){1'b0}}, m_dout});
    chk("dout_ch",    {30'b0, dout_ch},                 m_dch);
    chk("overflow",   {31'b0, overflow},                m_ovf);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Feed one word into channel 0 (only channel enabled, scan already at
  // dwell cycle 0). Each bit is held on d0 for a whole dwell.
  task automatic feed_ch0(input logic [7:0] word, input string tag);
    for (int i = 0; i < 8; i++) begin
      src_bits[0] = word[7-i];
      tick();
      tick();  // sampling edge
      if (i == 7) begin
        chk({tag, "_valid"}, {31'b0, dout_valid}, 1);
        chk({tag, "_dout"},  {24'b0, dout},       {24'b0, word});
        chk({tag, "_ch"},    {30'b0, dout_ch},    0);
      end
      tick();
      if (i == 7) chk({tag, "_valid_1cyc"}, {31'b0, dout_valid}, 0);
      tick();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [WW-1:0] held;

  initial begin
    rst        = 1'b1;
    en         = 1'b0;
    ch_mask    = 4'b0000;
    dout_ready = 1'b0;
    clr_ovf    = 1'b0;
    src_bits   = 4'b0000;
    model_reset();

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    chk("rst_sel",      {30'b0, s1, s0},      0);
    chk("rst_valid",    {31'b0, dout_valid},  0);
    chk("rst_dout",     {24'b0, dout},        0);
    chk("rst_overflow", {31'b0, overflow},    0);
    chk("rst_state",    {31'b0, state_dbg},   {31'b0, ST_IDLE});

    // 1: mask 0101 alternates 00 / 10 every dwell
    ch_mask    = 4'b0101;
    en         = 1'b1;
    dout_ready = 1'b1;
    tick();
    for (int k = 0; k < 16; k++) begin
      src_bits = 4'($urandom);
      chk("t1_sel", {30'b0, s1, s0}, ((k / 4) % 2 == 1) ? 2 : 0);
      tick();
    end

    // 2: single channel word 8'hA5
    do_reset();
    ch_mask    = 4'b0001;
    en         = 1'b1;
    dout_ready = 1'b1;
    src_bits   = 4'b0000;
    tick();
    feed_ch0(8'hA5, "t2");

    // 3: hold with ready=0, overflow, clear vs simultaneous drop
    do_reset();
    ch_mask    = 4'b0011;
    dout_ready = 1'b0;
    for (int k = 0; k < 300 && !dout_valid; k++) begin
      src_bits = 4'($urandom);
      tick();
    end
    chk("t3_first_valid", {31'b0, dout_valid}, 1);
    chk("t3_first_ch",    {30'b0, dout_ch},    0);
    held = dout;
    for (int k = 0; k < 100 && !overflow; k++) begin
      src_bits = 4'($urandom);
      tick();
    end
    chk("t3_ovf_set",   {31'b0, overflow},  1);
    chk("t3_held_word", {24'b0, dout},      {24'b0, held});
    clr_ovf = 1'b1;
    tick();
    chk("t3_ovf_clr", {31'b0, overflow}, 0);
    for (int k = 0; k < 300 && !overflow; k++) begin
      src_bits = 4'($urandom);
      tick();
    end
    chk("t3_set_wins",   {31'b0, overflow}, 1);
    chk("t3_held_word2", {24'b0, dout},     {24'b0, held});
    clr_ovf = 1'b0;

    // 4: en dropped mid-word, partial word discarded
    do_reset();
    ch_mask    = 4'b0001;
    dout_ready = 1'b1;
    src_bits   = 4'b1111;
    tick();
    for (int k = 0; k < 3 * DW; k++) tick();
    en = 1'b0;
    for (int k = 0; k < DW; k++) tick();
    chk("t4_idle", {31'b0, state_dbg}, {31'b0, ST_IDLE});
    chk("t4_sel",  {30'b0, s1, s0},    0);
    en = 1'b1;
    tick();
    feed_ch0(8'h3C, "t4");

    // 5: empty mask stays idle; mask 1000 selects channel 3 next edge
    do_reset();
    ch_mask = 4'b0000;
    for (int k = 0; k < 5; k++) tick();
    chk("t5_idle",  {31'b0, state_dbg},  {31'b0, ST_IDLE});
    chk("t5_sel",   {30'b0, s1, s0},     0);
    chk("t5_valid", {31'b0, dout_valid}, 0);
    ch_mask = 4'b1000;
    tick();
    chk("t5_sel3",  {30'b0, s1, s0},     3);

    // 6: reset while a word is held and overflow is set
    do_reset();
    ch_mask    = 4'b0110;
    dout_ready = 1'b0;
    for (int k = 0; k < 300 && !overflow; k++) begin
      src_bits = 4'($urandom);
      tick();
    end
    chk("t6_pre_valid", {31'b0, dout_valid}, 1);
    chk("t6_pre_ovf",   {31'b0, overflow},   1);
    do_reset();
    chk("t6_valid", {31'b0, dout_valid}, 0);
    chk("t6_ovf",   {31'b0, overflow},   0);
    chk("t6_dout",  {24'b0, dout},       0);
    chk("t6_ch",    {30'b0, dout_ch},    0);
    chk("t6_sel",   {30'b0, s1, s0},     0);
    tick();
    chk("t6_restart_sel", {30'b0, s1, s0}, 1);

    // Randomized run
    for (int k = 0; k < 3000; k++) begin
      src_bits   = 4'($urandom);
      dout_ready = ($urandom_range(0, 3) != 0);
      clr_ovf    = ($urandom_range(0, 15) == 0);
      en         = ($urandom_range(0, 99) != 0);
      rst        = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 63) == 0) ch_mask = 4'($urandom);
      tick();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
